pump_pwm_gen: RTL and testbench
===============================

# pump_pwm_gen

Dual-channel PWM generator that drives pump A (fill) and pump B (drain) from the 8-bit duty commands issued by the filter control FSM. Duty commands are sampled only at PWM period boundaries, so the outputs stay glitch-free. An optional soft-start ramp limits inrush on rising duty. The block sits between the filter control FSM and the pump driver pins.

## Interface
- PRESCALE_DIV, 10: clk cycles per PWM counter step; must be ≥1. The default gives 50 MHz/(10·255) ≈ 19.6 kHz.
- RAMP_STEP, 8: maximum rise of an applied duty per period, used only with soft-start.
- clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high.
- enable  input  1  run request. Low forces IDLE.
- duty_a_in  input  8  requested duty for pump A, 0..255.
- duty_b_in  input  8  requested duty for pump B, 0..255.
- pwm_a  output  1  pump A drive, registered.
- pwm_b  output  1  pump B drive, registered.
- period_start  output  1  one-cycle pulse on each period boundary.
- duty_a_applied  output  8  duty currently in effect for A.
- duty_b_applied  output  8  duty currently in effect for B.

## Operation
- FSM with two states, IDLE and RUN. Reset state is IDLE.
  - IDLE: prescaler = 0, cnt = 0, applied duties = 0, pwm outputs driven 0.
  - IDLE→RUN when enable = 1. The transition cycle is a period boundary.
  - RUN→IDLE when enable = 0. This check has priority over everything else in the cycle.
- Prescaler counts 0..PRESCALE_DIV−1. On wrap it produces a tick.
- cnt (8 bits) advances on each tick and runs 0..254, wrapping 254→0 (255 steps per period).
- Period boundary events:
  - the IDLE→RUN cycle, or
  - a tick with cnt = 254.
- At a period boundary:
  - duty_x_in is sampled into duty_x_applied;
  - period_start = 1 in the following cycle.
- Duty inputs are ignored at all other times.
- Compare rule: pwm_x ← (state == RUN) && enable && (cnt < duty_x_applied).
  - duty 0: output constantly low.
  - duty 255: output constantly high.
  - duty d: high for d·PRESCALE_DIV clocks per period.
- Channels are independent. Simultaneous nonzero A and B duties are legal and are passed through unchanged.

## Timing
- Reset values: pwm_a, pwm_b, period_start, duty_a_applied and duty_b_applied are all 0. state = IDLE, cnt = 0, prescaler = 0.
- Reset acts immediately (asynchronous), including in the middle of a high phase.
- pwm_x lags (cnt, applied) by one clk.
- A new duty is visible on pwm_x one clk after the boundary that sampled it.
- A duty change in mid-period never alters the current period.
- enable falling: pwm outputs are 0 in the next cycle, and applied duties are 0 in the next cycle.
- enable rising: the boundary happens in the same cycle. The first high level on pwm appears 1 clk later, provided the sampled duty is nonzero.
- Period = 255·PRESCALE_DIV clk.

## Configuration
- Macro: PUMP_PWM_SOFT_START_EN.
- Defined: at each boundary, when target > applied, applied ← min(target, applied + RAMP_STEP).
  - The addition is computed in 9 bits, so no wrap is possible.
  - When target ≤ applied, applied ← target immediately, so stopping is never delayed.
  - The IDLE→RUN boundary starts the ramp from 0.
- Undefined: applied ← target at every boundary, and RAMP_STEP is unused.

## Structure
- Shared package filter_pkg holds:
  - PWM_MAX (230) and PWM_MIN (77);
  - the pwm_state_t enum (IDLE, RUN);
  - the PWM_CNT_TOP constant (254).
- Sub-module pump_pwm_channel, instantiated twice. Each instance contains:
  - its applied-duty register;
  - the ramp logic;
  - the compare logic and output flop.
- Counters, prescaler and FSM stay shared in pump_pwm_gen.

## Test plan
All scenarios use PRESCALE_DIV = 2, so the period is 510 clk.
1. No macro, enable = 1, duty_a_in = 230 → after period_start, pwm_a is high for 460 clk and low for 50 clk in each period. pwm_b stays 0.
2. duty_a_in changes 77→230 when cnt = 100 → the current period keeps 154 high clk. The next period has 460 high clk, and duty_a_applied updates exactly at period_start.
3. Macro defined, RAMP_STEP = 8, duty_b_in 0→230 on enable → duty_b_applied steps through 8, 16, …, 224, 230 over 29 consecutive boundaries, then holds at 230.
4. Macro defined, duty_b_applied = 230, duty_b_in set to 0 → duty_b_applied is 0 at the next boundary, and pwm_b is low from then on.
5. enable is dropped during a pwm_a high phase → pwm_a = 0 on the next clk, applied duties are 0, and the FSM is in IDLE. Asserting reset in mid-period drives all outputs to 0 immediately.
6. Duty 255 on A and 0 on B across 3 periods → pwm_a stays 1 and pwm_b stays 0 continuously, with no glitch at the boundaries.

Source files
------------

// File: rtl/filter_pkg.sv
// ---------------------------------------------------------------------------
// filter_pkg
// Shared definitions for the filter control slice: duty limits used by the
// filter control FSM, the PWM generator state type, the PWM counter top value
// and the soft-start ramp helper.
// Optional feature macro consumed by users of ramp_limit():
// PUMP_PWM_SOFT_START_EN.
// ---------------------------------------------------------------------------
package filter_pkg;

    localparam logic [7:0] PWM_MAX     = 8'd230;
    localparam logic [7:0] PWM_MIN     = 8'd77;
    localparam logic [7:0] PWM_CNT_TOP = 8'd254;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_t;

    // Next applied duty while ramping up. The sum is 9 bits wide so that
    // applied + step can never wrap past 255.
    function automatic logic [7:0] ramp_limit(input logic [7:0] target,
                                              input logic [7:0] applied,
                                              input logic [7:0] step);
        logic [8:0] sum;
        sum = {1'b0, applied} + {1'b0, step};
        if ({1'b0, target} <= sum) begin
            ramp_limit = target;
        end else begin
            ramp_limit = sum[7:0];
        end
    endfunction

endpackage

// File: rtl/pump_pwm_channel.sv
// ---------------------------------------------------------------------------
// pump_pwm_channel
// One PWM channel: applied-duty register, optional soft-start ramp, compare
// against the shared period counter and the registered drive output.
// Macro: PUMP_PWM_SOFT_START_EN enables the rise-limited ramp.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   enable_i     run request; low clears the applied duty
//   sample_i     period boundary strobe; duty_i is captured only here
//   run_i        generator is in RUN with enable high
//   duty_i       requested duty 0..255
//   cnt_i        shared period counter 0..254
//   pwm_o        registered drive output
//   applied_o    duty currently in effect
// ---------------------------------------------------------------------------
module pump_pwm_channel
    import filter_pkg::*;
#(
    parameter int RAMP_STEP = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable_i,
    input  logic       sample_i,
    input  logic       run_i,
    input  logic [7:0] duty_i,
    input  logic [7:0] cnt_i,
    output logic       pwm_o,
    output logic [7:0] applied_o
);

    if (RAMP_STEP < 1 || RAMP_STEP > 255) begin : g_bad_ramp_step
        $error("pump_pwm_channel: RAMP_STEP must be in 1..255");
    end

    logic [7:0] applied_q, applied_d;
    logic [7:0] next_duty;
    logic       pwm_q, pwm_d;

`ifdef PUMP_PWM_SOFT_START_EN
    localparam logic [7:0] STEP8 = RAMP_STEP[7:0];

    // Rising duty is rate limited; falling duty applies at once so that a
    // stop request is never delayed.
    always_comb begin
        next_duty = duty_i;
        if (duty_i > applied_q) begin
            next_duty = ramp_limit(duty_i, applied_q, STEP8);
        end
    end
`else
    always_comb begin
        next_duty = duty_i;
    end
`endif

    // applied_q is already 0 in IDLE, so the IDLE->RUN boundary ramps from 0.
    always_comb begin
        applied_d = applied_q;
        if (!enable_i) begin
            applied_d = '0;
        end else if (sample_i) begin
            applied_d = next_duty;
        end
    end

    // Output lags (cnt, applied) by one clock; cnt tops out at 254, so a
    // duty of 255 keeps the output high across the boundary.
    always_comb begin
        pwm_d = run_i && (cnt_i < applied_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            applied_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            applied_q <= applied_d;
            pwm_q     <= pwm_d;
        end
    end

    assign pwm_o     = pwm_q;
    assign applied_o = applied_q;

endmodule

// File: rtl/pump_pwm_gen.sv
// ---------------------------------------------------------------------------
// pump_pwm_gen
// Dual-channel pump PWM generator (A = fill, B = drain). Duty commands are
// captured only at period boundaries so outputs never glitch mid-period.
// Macro: PUMP_PWM_SOFT_START_EN enables the soft-start ramp in both channels.
// Ports:
//   clk, reset        50 MHz clock, asynchronous active-high reset
//   enable            run request; low forces IDLE
//   duty_a_in/_b_in   requested duties 0..255
//   pwm_a, pwm_b      registered pump drives
//   period_start      one-cycle pulse in the cycle after each boundary
//   duty_a_applied    duty in effect for A
//   duty_b_applied    duty in effect for B
//   state_dbg         current FSM state
// Handshake: none; duty inputs are level commands sampled on boundaries.
// ---------------------------------------------------------------------------
module pump_pwm_gen
    import filter_pkg::*;
#(
    parameter int PRESCALE_DIV = 10,
    parameter int RAMP_STEP    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] duty_a_in,
    input  logic [7:0] duty_b_in,
    output logic       pwm_a,
    output logic       pwm_b,
    output logic       period_start,
    output logic [7:0] duty_a_applied,
    output logic [7:0] duty_b_applied,
    output pwm_state_t state_dbg
);

    if (PRESCALE_DIV < 1) begin : g_bad_prescale
        $error("pump_pwm_gen: PRESCALE_DIV must be >= 1");
    end

    localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [PW-1:0] PRESC_TOP = PW'(PRESCALE_DIV - 1);

    pwm_state_t    state_q;
    logic [PW-1:0] presc_q;
    logic [7:0]    cnt_q;
    logic          period_start_q;

    logic tick;
    logic boundary;
    logic run;

    assign tick = (presc_q == PRESC_TOP);
    assign run  = (state_q == RUN) && enable;
    // Entering RUN is itself a boundary; otherwise the last step of the count.
    assign boundary = enable &&
                      ((state_q == IDLE) || (tick && (cnt_q == PWM_CNT_TOP)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            presc_q        <= '0;
            cnt_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    presc_q        <= '0;
                    cnt_q          <= '0;
                    period_start_q <= enable;
                    if (enable) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state_q        <= IDLE;
                        presc_q        <= '0;
                        cnt_q          <= '0;
                        period_start_q <= 1'b0;
                    end else begin
                        period_start_q <= boundary;
                        if (tick) begin
                            presc_q <= '0;
                            cnt_q   <= (cnt_q == PWM_CNT_TOP) ? 8'd0 : cnt_q + 8'd1;
                        end else begin
                            presc_q <= presc_q + PW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    pump_pwm_channel #(.RAMP_STEP(RAMP_STEP)) u_chan_a (
        .clk       (clk),
        .reset     (reset),
        .enable_i  (enable),
        .sample_i  (boundary),
        .run_i     (run),
        .duty_i    (duty_a_in),
        .cnt_i     (cnt_q),
        .pwm_o     (pwm_a),
        .applied_o (duty_a_applied)
    );

    pump_pwm_channel #(.RAMP_STEP(RAMP_STEP)) u_chan_b (
        .clk       (clk),
        .reset     (reset),
        .enable_i  (enable),
        .sample_i  (boundary),
        .run_i     (run),
        .duty_i    (duty_b_in),
        .cnt_i     (cnt_q),
        .pwm_o     (pwm_b),
        .applied_o (duty_b_applied)
    );

    assign period_start = period_start_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_pump_pwm_gen.sv
// ---------------------------------------------------------------------------
// tb_pump_pwm_gen
// Bench for pump_pwm_gen with PRESCALE_DIV = 2 (510-clock periods).
// Honours PUMP_PWM_SOFT_START_EN for both the DUT and the reference model.
// ---------------------------------------------------------------------------
module tb_pump_pwm_gen;
    import filter_pkg::*;

    localparam int DIV  = 2;
    localparam int STEP = 8;
    localparam int PER  = 255 * DIV;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] duty_a_in = 8'd0;
    logic [7:0] duty_b_in = 8'd0;
    logic       pwm_a, pwm_b, period_start;
    logic [7:0] duty_a_applied, duty_b_applied;
    pwm_state_t state_dbg;

    always #5 clk = ~clk;

    pump_pwm_gen #(.PRESCALE_DIV(DIV), .RAMP_STEP(STEP)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .duty_a_in      (duty_a_in),
        .duty_b_in      (duty_b_in),
        .pwm_a          (pwm_a),
        .pwm_b          (pwm_b),
        .period_start   (period_start),
        .duty_a_applied (duty_a_applied),
        .duty_b_applied (duty_b_applied),
        .state_dbg      (state_dbg)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks position inside the period in clocks since the last boundary;
    // the drive is high while (position / DIV) is below the applied duty.
    bit m_run;
    int m_pos;
    int m_app_a, m_app_b;
    bit m_pwm_a, m_pwm_b, m_ps;

    function automatic int next_duty(input int tgt, input int cur);
`ifdef PUMP_PWM_SOFT_START_EN
        if (tgt > cur) return (cur + STEP < tgt) ? cur + STEP : tgt;
`endif
        return tgt;
    endfunction

    task automatic model_clear();
        m_run = 0; m_pos = 0; m_app_a = 0; m_app_b = 0;
        m_pwm_a = 0; m_pwm_b = 0; m_ps = 0;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_clear();
        end else if (!m_run) begin
            m_pwm_a = 0; m_pwm_b = 0;
            if (enable) begin
                m_run = 1; m_pos = 0; m_ps = 1;
                m_app_a = next_duty(int'(duty_a_in), 0);
                m_app_b = next_duty(int'(duty_b_in), 0);
            end else begin
                m_ps = 0;
            end
        end else if (!enable) begin
            model_clear();
        end else begin
            m_pwm_a = (m_pos / DIV) < m_app_a;
            m_pwm_b = (m_pos / DIV) < m_app_b;
            m_pos++;
            if (m_pos == PER) begin
                m_pos = 0; m_ps = 1;
                m_app_a = next_duty(int'(duty_a_in), m_app_a);
                m_app_b = next_duty(int'(duty_b_in), m_app_b);
            end else begin
                m_ps = 0;
            end
        end
    end

    // ---------------- scoreboard: every-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check("pwm_a", pwm_a, m_pwm_a);
            check("pwm_b", pwm_b, m_pwm_b);
            check("period_start", period_start, m_ps);
            check("duty_a_applied", duty_a_applied, m_app_a);
            check("duty_b_applied", duty_b_applied, m_app_b);
            check("state", 32'(state_dbg), m_run ? 32'd1 : 32'd0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ps(output bit ok);
        ok = 0;
        for (int i = 0; i < PER + 10; i++) begin
            @(negedge clk);
            if (period_start) begin
                ok = 1;
                return;
            end
        end
        n_cmp++; n_fail++;
        $display("FAIL period_start_timeout: got no pulse expected one within %0d clk", PER + 10);
    endtask

    // Counts high samples over one whole period starting at the period_start
    // sample. Optionally changes duty_a_in at sample index chg_at.
    task automatic measure(input int chg_at, input logic [7:0] chg_duty,
                           output int ha, output int hb,
                           output int a0, output int b0, output int a_last);
        bit ok;
        ha = 0; hb = 0; a0 = -1; b0 = -1; a_last = -1;
        wait_ps(ok);
        if (!ok) return;
        a0 = duty_a_applied; b0 = duty_b_applied;
        ha += pwm_a; hb += pwm_b;
        for (int j = 1; j < PER; j++) begin
            @(negedge clk);
            if (j == chg_at) duty_a_in = chg_duty;
            ha += pwm_a; hb += pwm_b;
        end
        a_last = duty_a_applied;
    endtask

    task automatic wait_pwm_a_high();
        for (int i = 0; i < 2 * PER; i++) begin
            @(negedge clk);
            if (pwm_a) return;
        end
        n_cmp++; n_fail++;
        $display("FAIL pwm_a_high_timeout: got no high expected one within %0d clk", 2 * PER);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int ha, hb, a0, b0, al;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_pwm_a", pwm_a, 0);
        check("rst_pwm_b", pwm_b, 0);
        check("rst_period_start", period_start, 0);
        check("rst_app_a", duty_a_applied, 0);
        check("rst_app_b", duty_b_applied, 0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        chk_en = 1'b1;

`ifndef PUMP_PWM_SOFT_START_EN
        // Duty 230 on A, 0 on B.
        duty_a_in = PWM_MAX; duty_b_in = 8'd0; enable = 1'b1;
        measure(-1, 8'd0, ha, hb, a0, b0, al);
        check("p1_high_a", ha, 460);
        check("p1_high_b", hb, 0);
        check("p1_app_a", a0, 230);
        measure(-1, 8'd0, ha, hb, a0, b0, al);
        check("p2_high_a", ha, 460);

        // 77 applied, change to 230 at cnt = 100 mid-period.
        duty_a_in = PWM_MIN;
        measure(200, PWM_MAX, ha, hb, a0, b0, al);
        check("mid_high_a", ha, 154);
        check("mid_app_start", a0, 77);
        check("mid_app_end", al, 77);
        measure(-1, 8'd0, ha, hb, a0, b0, al);
        check("after_high_a", ha, 460);
        check("after_app_a", a0, 230);

        // Duty 255 / 0 across three periods (one settling period first).
        duty_a_in = 8'd255; duty_b_in = 8'd0;
        measure(-1, 8'd0, ha, hb, a0, b0, al);
        check("full_settle_a", ha, 509);
        for (int k = 0; k < 3; k++) begin
            measure(-1, 8'd0, ha, hb, a0, b0, al);
            check("full_high_a", ha, 510);
            check("full_high_b", hb, 0);
        end

        // Both channels nonzero.
        duty_a_in = 8'd100; duty_b_in = 8'd50;
        measure(-1, 8'd0, ha, hb, a0, b0, al);
        measure(-1, 8'd0, ha, hb, a0, b0, al);
        check("dual_high_a", ha, 200);
        check("dual_high_b", hb, 100);
`else
        // Ramp B from 0 to 230 starting at the IDLE->RUN boundary.
        duty_a_in = 8'd0; duty_b_in = PWM_MAX; enable = 1'b1;
        for (int k = 0; k < 29; k++) begin
            measure(-1, 8'd0, ha, hb, a0, b0, al);
            check("ramp_app_b", b0, (8 * (k + 1) < 230) ? 8 * (k + 1) : 230);
        end
        measure(-1, 8'd0, ha, hb, a0, b0, al);
        check("ramp_hold_b", b0, 230);
        check("ramp_hold_high_b", hb, 460);

        // Ramp-down is immediate.
        duty_b_in = 8'd0;
        measure(-1, 8'd0, ha, hb, a0, b0, al);
        check("stop_app_b", b0, 0);
        check("stop_high_b", hb, 0);
`endif

        // Drop enable during an A high phase.
        duty_a_in = 8'd200;
        wait_pwm_a_high();
        enable = 1'b0;
        @(negedge clk);
        check("drop_pwm_a", pwm_a, 0);
        check("drop_app_a", duty_a_applied, 0);
        check("drop_app_b", duty_b_applied, 0);
        check("drop_state", 32'(state_dbg), 32'(IDLE));

        // Re-enable: boundary in the same cycle, first high one clock later.
        duty_a_in = 8'd255;
        enable = 1'b1;
        @(negedge clk);
        check("rise_ps", period_start, 1);
        check("rise_pwm_a", pwm_a, 0);
`ifdef PUMP_PWM_SOFT_START_EN
        check("rise_app_a", duty_a_applied, 8);
`else
        check("rise_app_a", duty_a_applied, 255);
`endif
        @(negedge clk);
        check("rise_pwm_a_next", pwm_a, 1);

        // Asynchronous reset in the middle of a high phase.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_pwm_a", pwm_a, 0);
        check("arst_app_a", duty_a_applied, 0);
        check("arst_ps", period_start, 0);
        check("arst_state", 32'(state_dbg), 32'(IDLE));
        @(negedge clk);
        reset = 1'b0;

        // Randomised duties, enable toggles and mid-period changes.
        for (int it = 0; it < 16; it++) begin
            duty_a_in = 8'($urandom_range(0, 255));
            duty_b_in = 8'($urandom_range(0, 255));
            enable    = ($urandom_range(0, 5) != 0);
            repeat ($urandom_range(1, PER + 200)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) begin
                duty_a_in = 8'($urandom_range(0, 255));
                repeat ($urandom_range(1, PER)) @(negedge clk);
            end
        end
        enable = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
